// File: rtl/bram_pixel_reader_if.sv
// Pixel stream bundle for bram_pixel_reader.
// Valid/ready handshake carrying one 8-bit pixel plus end-of-frame.
interface bram_pixel_reader_if;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] pix_data;
  logic       pix_last;

  modport master (
    output pix_valid,
    output pix_data,
    output pix_last,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_data,
    input  pix_last,
    output pix_ready
  );
endinterface

// File: rtl/bram_pixel_reader.sv
// Frame BRAM port-B reader: 32-bit words -> 8-bit pixel stream.
// Define BRAM_READER_MSB_FIRST_EN for byte3-first unpacking.
module bram_pixel_reader #(
  parameter int ADDR_W       = 10,
  parameter int NUM_WORDS    = 256,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              enb,
  output logic [ADDR_W-1:0] addrb,
  input  logic [31:0]       doutb,
  output logic              busy,
  output logic              done,
  bram_pixel_reader_if.master pix
);

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
    $error("READ_LATENCY must be 1 or 2");
  end

  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W:0] LAST_WORD =
    (ADDR_W+1)'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0]       addr;
  logic [READ_LATENCY-1:0] vld;
  logic [1:0]              inflight;
  logic [2:0]              occ;
  logic                    cap;

  logic [31:0] fifo_mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  fifo_cnt;

  logic [31:0]   out_word;
  logic          out_full;
  logic          out_is_last;
  logic [1:0]    byte_idx;
  logic [1:0]    sel;
  logic [ADDR_W:0] ld_cnt;

  logic fire;
  logic emptying;
  logic out_free;
  logic bypass;
  logic pop;
  logic push;
  logic load;
  logic last_fire;
  logic [31:0] load_word;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + {1'b0, vld[i]};
    end
  end

  assign occ = {1'b0, fifo_cnt} + {1'b0, inflight};
  assign cap = vld[READ_LATENCY-1];

  assign fire      = out_full && pix.pix_ready;
  assign emptying  = fire && (byte_idx == 2'd3);
  assign out_free  = !out_full || emptying;
  assign pop       = out_free && (fifo_cnt != 2'd0);
  assign bypass    = out_free && (fifo_cnt == 2'd0) && cap;
  assign push      = cap && !bypass;
  assign load      = pop || bypass;
  assign load_word = pop ? fifo_mem[rd_ptr] : doutb;
  assign last_fire = fire && pix.pix_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    enb     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = READ;
      end
      READ: begin
        enb = (occ < 3'd2);
        if (enb && addr == LAST_ADDR) state_n = DRAIN;
      end
      DRAIN: begin
        if (last_fire) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign addrb = addr;
  assign busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      done <= 1'b0;
    end else begin
      done <= (state == DRAIN) && last_fire;
      if (state == IDLE && start) addr <= '0;
      else if (enb) addr <= addr + 1'b1;
    end
  end

  // Read-return tracker: a set bit at the top means doutb is valid now.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else begin
      vld[0] <= enb;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= doutb;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_word    <= '0;
      out_full    <= 1'b0;
      out_is_last <= 1'b0;
      byte_idx    <= 2'd0;
      ld_cnt      <= '0;
    end else begin
      if (state == IDLE && start) ld_cnt <= '0;
      else if (load) ld_cnt <= ld_cnt + 1'b1;
      if (load) begin
        out_word    <= load_word;
        out_full    <= 1'b1;
        out_is_last <= (ld_cnt == LAST_WORD);
        byte_idx    <= 2'd0;
      end else if (emptying) begin
        out_full <= 1'b0;
        byte_idx <= 2'd0;
      end else if (fire) begin
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

`ifdef BRAM_READER_MSB_FIRST_EN
  assign sel = 2'd3 - byte_idx;
`else
  assign sel = byte_idx;
`endif

  assign pix.pix_valid = out_full;
  assign pix.pix_data  = out_word[{sel, 3'b000} +: 8];
  assign pix.pix_last  = out_full && out_is_last &&
                         (byte_idx == 2'd3);

endmodule

// File: doc/bram_pixel_reader.md
# bram_pixel_reader

Read-side controller for the frame BRAM. It sequences port-B reads across a frame of 32-bit words and unpacks each word into four 8-bit pixels. The pixels leave as a valid/ready stream with an end-of-frame marker. It sits between the frame BRAM (port B) and the downstream pixel-processing pipeline, and it replaces free-running combinational word splitting with a backpressure-aware stream.

## Interface
- `ADDR_W`, 10: BRAM port-B address width.
- `NUM_WORDS`, 256: words per frame, range 1..2^ADDR_W. Pixels per frame = 4*NUM_WORDS.
- `READ_LATENCY`, 1: cycles from `enb`/`addrb` to valid `doutb`. Legal values are 1 or 2; any other value is a synthesis error.

- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: frame request, sampled only in IDLE.
- `enb` output 1: BRAM port-B read enable.
- `addrb` output ADDR_W: BRAM port-B read address.
- `doutb` input 32: BRAM port-B read data.
- `pix_valid` output 1: `pix_data` is valid.
- `pix_ready` input 1: downstream accepts the pixel.
- `pix_data` output 8: current pixel.
- `pix_last` output 1: last pixel of the frame; qualified by `pix_valid`.
- `busy` output 1: frame in progress.
- `done` output 1: one-cycle pulse after the last pixel transfer.

## Operation
- Reset values:
  - `enb`, `addrb`, `pix_valid`, `pix_data`, `pix_last`, `busy`, `done` are all 0.
  - FSM is in IDLE; word FIFO is empty; in-flight counter is 0; byte index is 0.
- FSM states:
  - IDLE: when `start`=1, go to READ, set `busy`=1, reset the address counter to 0.
  - READ: issue reads. After the read of address NUM_WORDS-1 is issued, go to DRAIN.
  - DRAIN: wait for the pixel transfer with `pix_last`=1, then pulse `done`, clear `busy`, return to IDLE.
- `start` is ignored outside IDLE.
- Read issue:
  - `enb`=1 with `addrb`=addr in a READ cycle only when (in-flight reads + FIFO occupancy) < 2.
  - addr increments by 1 per issued read and never wraps within a frame.
  - No read is ever issued whose data could not be stored.
- Word storage:
  - A 2-entry word FIFO feeds the output word register.
  - Returning `doutb` is captured exactly READ_LATENCY cycles after its `enb`.
  - If the output register is empty, or is being emptied that cycle, the word bypasses the FIFO straight into the output register.
- Unpacking:
  - Byte order is byte0=`doutb[7:0]`, byte1=`[15:8]`, byte2=`[23:16]`, byte3=`[31:24]`.
  - Byte index advances on each `pix_valid && pix_ready`.
  - After byte3 transfers, the next word loads in the same cycle if one is available; otherwise `pix_valid` drops.
- `pix_last` = (output word is word NUM_WORDS-1) && (byte index == 3).
- Handshake rules:
  - Once `pix_valid` is asserted, `pix_data` and `pix_last` stay stable until the transfer.
  - `pix_valid` does not depend combinationally on `pix_ready`.
- `rst` mid-frame: every output returns to its reset value on the next edge. In-flight BRAM data is discarded, and a new `start` is accepted from IDLE.

## Timing
- Cycle 0: `start` is high in IDLE.
- Cycle 1: first `enb`=1, `addrb`=0.
- Cycle 2+READ_LATENCY: first `pix_valid`=1 with byte0 of word 0.
- Sustained throughput with `pix_ready` held at 1 is one pixel per cycle, with no bubbles between words for either READ_LATENCY.
- `done` is high the cycle after the `pix_last` transfer; `busy` falls in the same cycle.
- A new `start` is accepted the cycle `done` is high at the earliest, because the FSM is already in IDLE.
- NUM_WORDS=1: a single read is issued, then FSM goes directly to DRAIN.

## Configuration
- `BRAM_READER_MSB_FIRST_EN`:
  - Defined: each word is emitted byte3, byte2, byte1, byte0, and `pix_last` marks byte0 of the last word.
  - Undefined (default): LSB-first order as in Operation.

## Test plan
- NUM_WORDS=4, word k = {4k+3, 4k+2, 4k+1, 4k}, `pix_ready`=1 → pixels 0..15 on 16 consecutive cycles from cycle 3, `pix_last` with pixel 15, `done` one cycle later, exactly 4 `enb` pulses at addresses 0..3.
- Same frame with pseudo-random `pix_ready` (50%) → identical pixel sequence, `pix_data` stable while stalled, in-flight+FIFO never exceeds 2.
- `start` pulsed during READ and during DRAIN → ignored; exactly one frame is produced and `done` pulses once.
- `rst` asserted at the 6th pixel → next cycle all outputs are 0; a fresh `start` then yields pixels 0..15 correctly.
- READ_LATENCY=2, NUM_WORDS=1, word 0xDDCCBBAA → first `pix_valid` at cycle 4 with AA, BB, CC, DD, `pix_last` on DD.
- `BRAM_READER_MSB_FIRST_EN` defined, word 0xDDCCBBAA → DD, CC, BB, AA, `pix_last` on AA.
